mem_wb_stage: RTL and testbench

//   MEM/WB pipeline register and write-back stage; consumes MEM_Unit outputs.

---
 rtl/mem_wb_stage.sv | 118 +++++++++++
 tb/tb_mem_wb_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: picks the write-back value,
// drives the register-file write port and forwarding taps, counts retirements,
// and stalls the pipe while a popped return PC waits for fetch to take it.
module mem_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  RegWrite_in,
    input  logic                  mem_to_reg_in,
    input  logic                  ret_future_in,
    input  logic [REG_ADDR_W-1:0] reg_rd_in,
    input  logic [DATA_W-1:0]     mem_read_data,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic                  ret_pc_ack,
    output logic                  reg_we,
    output logic [REG_ADDR_W-1:0] reg_wr_addr,
    output logic [DATA_W-1:0]     reg_wr_data,
    output logic                  fwd_valid,
    output logic                  ret_pc_valid,
    output logic [DATA_W-1:0]     ret_pc,
    output logic                  stage_busy,
    output logic [15:0]           retire_cnt
);

    typedef enum logic {IDLE, RET_REQ} state_t;

    state_t                  state_q, state_d;
    logic                    wb_pend_q, wb_pend_d;
    logic                    rw_q, rw_d;
    logic                    m2r_q, m2r_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]       mem_q, mem_d;
    logic [DATA_W-1:0]       alu_q, alu_d;
    logic [DATA_W-1:0]       ret_pc_q, ret_pc_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    busy;
    logic                    capture;

    assign busy    = (state_q == RET_REQ);
    assign capture = !flush && !stall && !busy;

    always_comb begin
        state_d   = state_q;
        wb_pend_d = 1'b0;
        rw_d      = rw_q;
        m2r_d     = m2r_q;
        rd_d      = rd_q;
        mem_d     = mem_q;
        alu_d     = alu_q;
        ret_pc_d  = ret_pc_q;
        cnt_d     = cnt_q + {15'd0, wb_pend_q};

        // Clearing wb_pend on hold keeps each captured instruction to one write.
        if (flush) begin
            rw_d = 1'b0;
        end else if (capture) begin
            wb_pend_d = valid_in;
            rw_d      = RegWrite_in;
            m2r_d     = mem_to_reg_in;
            rd_d      = reg_rd_in;
            mem_d     = mem_read_data;
            alu_d     = alu_result_in;
        end

        // Flush does not touch the return FSM: a pending return must reach fetch.
        case (state_q)
            IDLE: begin
                if (capture && valid_in && ret_future_in) begin
                    state_d  = RET_REQ;
                    ret_pc_d = mem_read_data;
                end
            end
            RET_REQ: begin
                if (ret_pc_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wb_pend_q <= 1'b0;
            rw_q      <= 1'b0;
            m2r_q     <= 1'b0;
            rd_q      <= '0;
            mem_q     <= '0;
            alu_q     <= '0;
            ret_pc_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wb_pend_q <= wb_pend_d;
            rw_q      <= rw_d;
            m2r_q     <= m2r_d;
            rd_q      <= rd_d;
            mem_q     <= mem_d;
            alu_q     <= alu_d;
            ret_pc_q  <= ret_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign reg_we       = wb_pend_q && rw_q && (rd_q != '0);
    assign reg_wr_addr  = rd_q;
    assign reg_wr_data  = m2r_q ? mem_q : alu_q;
    assign fwd_valid    = reg_we;
    assign ret_pc_valid = busy;
    assign stage_busy   = busy;
    assign ret_pc       = ret_pc_q;
    assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus a random run scored against
// an instruction-level model of write-back, retire counting and return handoff.
module tb_mem_wb_stage;

    logic        clk, rst, stall, flush, valid_in, RegWrite_in, mem_to_reg_in, ret_future_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] mem_read_data, alu_result_in;
    logic        ret_pc_ack;
    logic        reg_we, fwd_valid, ret_pc_valid, stage_busy;
    logic [3:0]  reg_wr_addr;
    logic [15:0] reg_wr_data, ret_pc, retire_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .RegWrite_in(RegWrite_in), .mem_to_reg_in(mem_to_reg_in),
        .ret_future_in(ret_future_in), .reg_rd_in(reg_rd_in),
        .mem_read_data(mem_read_data), .alu_result_in(alu_result_in),
        .ret_pc_ack(ret_pc_ack), .reg_we(reg_we), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .fwd_valid(fwd_valid), .ret_pc_valid(ret_pc_valid),
        .ret_pc(ret_pc), .stage_busy(stage_busy), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instruction waiting to write back (if any), the outstanding
    // return, and the number of instructions that have retired.
    logic        m_pend, m_wr, m_ret_wait;
    logic [3:0]  m_rd;
    logic [15:0] m_val, m_ret_pc, m_cnt;

    task automatic model_edge();
        logic can_take;
        if (rst) begin
            m_pend = 0; m_wr = 0; m_ret_wait = 0; m_rd = 0; m_val = 0; m_ret_pc = 0; m_cnt = 0;
        end else begin
            if (m_pend) m_cnt = m_cnt + 16'd1;
            can_take = !flush && !stall && !m_ret_wait;
            if (m_ret_wait) begin
                if (ret_pc_ack) m_ret_wait = 0;
            end else if (can_take && valid_in && ret_future_in) begin
                m_ret_wait = 1;
                m_ret_pc   = mem_read_data;
            end
            m_pend = can_take && valid_in;
            if (m_pend) begin
                m_wr  = RegWrite_in && (reg_rd_in != 0);
                m_rd  = reg_rd_in;
                m_val = mem_to_reg_in ? mem_read_data : alu_result_in;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; valid_in = 0; RegWrite_in = 0; mem_to_reg_in = 0;
        ret_future_in = 0; reg_rd_in = 0; mem_read_data = 0; alu_result_in = 0; ret_pc_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_op(input logic v, input logic rw, input logic m2r, input logic rt,
                          input logic [3:0] rd, input logic [15:0] mem, input logic [15:0] alu);
        valid_in = v; RegWrite_in = rw; mem_to_reg_in = m2r; ret_future_in = rt;
        reg_rd_in = rd; mem_read_data = mem; alu_result_in = alu;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_op(1, 1, 1, 1, 4'd9, 16'hAAAA, 16'h5555);
        stall = 0;
        rst = 1;
        tick();
        tick();
        n_cmp++;
        if ({reg_we, fwd_valid, ret_pc_valid, stage_busy} !== 4'b0 || reg_wr_addr !== 0 ||
            reg_wr_data !== 0 || ret_pc !== 0 || retire_cnt !== 0) begin
            n_bad++;
            $display("FAIL reset_outputs: we=%0b fv=%0b rpv=%0b busy=%0b addr=%0h data=%0h rpc=%0h cnt=%0h, all required 0",
                     reg_we, fwd_valid, ret_pc_valid, stage_busy, reg_wr_addr, reg_wr_data, ret_pc, retire_cnt);
        end
        rst = 0;
    endtask

    task automatic test_load();
        do_reset();
        set_op(1, 1, 1, 0, 4'd3, 16'hBEEF, 16'h0040);
        tick();
        idle_inputs();
        n_cmp++;
        if (reg_we !== 1 || reg_wr_addr !== 4'd3 || reg_wr_data !== 16'hBEEF || fwd_valid !== 1) begin
            n_bad++;
            $display("FAIL load_write: we=%0b addr=%0h data=%0h fv=%0b, required 1/3/BEEF/1",
                     reg_we, reg_wr_addr, reg_wr_data, fwd_valid);
        end
        tick();
        n_cmp++;
        if (reg_we !== 0 || retire_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL load_after: we=%0b cnt=%0h, required 0/1", reg_we, retire_cnt);
        end
    endtask

    task automatic test_r0();
        do_reset();
        set_op(1, 1, 0, 0, 4'd0, 16'h1111, 16'h2222);
        tick();
        idle_inputs();
        n_cmp++;
        if (reg_we !== 0 || fwd_valid !== 0) begin
            n_bad++;
            $display("FAIL r0_suppress: we=%0b fv=%0b, required 0/0", reg_we, fwd_valid);
        end
        tick();
        n_cmp++;
        if (retire_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL r0_retire: cnt=%0h, required 1", retire_cnt);
        end
    endtask

    task automatic test_stall();
        int pulses;
        do_reset();
        set_op(1, 1, 0, 0, 4'd5, 16'h0000, 16'h1234);
        tick();
        pulses = int'(reg_we);
        n_cmp++;
        if (reg_wr_data !== 16'h1234 || reg_wr_addr !== 4'd5) begin
            n_bad++;
            $display("FAIL stall_first: addr=%0h data=%0h, required 5/1234", reg_wr_addr, reg_wr_data);
        end
        set_op(1, 1, 0, 0, 4'd6, 16'h0000, 16'h9999);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(reg_we);
            n_cmp++;
            if (reg_wr_addr !== 4'd5 || reg_wr_data !== 16'h1234) begin
                n_bad++;
                $display("FAIL stall_hold: cycle %0d addr=%0h data=%0h, required 5/1234", i, reg_wr_addr, reg_wr_data);
            end
        end
        idle_inputs();
        n_cmp++;
        if (pulses != 1 || retire_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL stall_once: pulses=%0d cnt=%0h, required 1/1", pulses, retire_cnt);
        end
    endtask

    task automatic test_ret();
        do_reset();
        set_op(1, 1, 1, 1, 4'd2, 16'h0100, 16'h0007);
        tick();
        n_cmp++;
        if (reg_we !== 1 || reg_wr_data !== 16'h0100) begin
            n_bad++;
            $display("FAIL ret_write: we=%0b data=%0h, required 1/0100", reg_we, reg_wr_data);
        end
        set_op(1, 1, 0, 0, 4'd7, 16'h0000, 16'h7777);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ret_pc_valid !== 1 || stage_busy !== 1 || ret_pc !== 16'h0100 || (i > 0 && reg_we !== 0)) begin
                n_bad++;
                $display("FAIL ret_wait: cycle %0d rpv=%0b busy=%0b rpc=%0h we=%0b, required 1/1/0100/0",
                         i, ret_pc_valid, stage_busy, ret_pc, reg_we);
            end
            flush = (i == 1);
            ret_pc_ack = (i == 3);
            tick();
        end
        flush = 0; ret_pc_ack = 0;
        n_cmp++;
        if (ret_pc_valid !== 0 || stage_busy !== 0 || reg_we !== 0) begin
            n_bad++;
            $display("FAIL ret_release: rpv=%0b busy=%0b we=%0b, required 0/0/0", ret_pc_valid, stage_busy, reg_we);
        end
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        do_reset();
        set_op(1, 1, 0, 0, 4'd6, 16'h0000, 16'h00AB);
        stall = 1; flush = 1;
        tick();
        idle_inputs();
        n_cmp++;
        if (reg_we !== 0) begin
            n_bad++;
            $display("FAIL stall_flush_we: we=%0b, required 0", reg_we);
        end
        tick();
        n_cmp++;
        if (retire_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL stall_flush_cnt: cnt=%0h, required 0", retire_cnt);
        end
    endtask

    task automatic test_wrap_and_ret_reset();
        do_reset();
        set_op(1, 0, 0, 0, 4'd1, 16'h0000, 16'h0000);
        for (int i = 0; i < 65535; i++) tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (retire_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_preload: cnt=%0h, required FFFF", retire_cnt);
        end
        set_op(1, 0, 0, 0, 4'd1, 16'h0000, 16'h0000);
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (retire_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_rollover: cnt=%0h, required 0000", retire_cnt);
        end
        set_op(1, 1, 1, 1, 4'd4, 16'h0ACE, 16'h0000);
        tick();
        idle_inputs();
        n_cmp++;
        if (ret_pc_valid !== 1 || reg_we !== 1) begin
            n_bad++;
            $display("FAIL rstret_enter: rpv=%0b we=%0b, required 1/1", ret_pc_valid, reg_we);
        end
        rst = 1;
        tick();
        rst = 0;
        n_cmp++;
        if ({reg_we, fwd_valid, ret_pc_valid, stage_busy} !== 4'b0 || reg_wr_addr !== 0 ||
            reg_wr_data !== 0 || ret_pc !== 0 || retire_cnt !== 0) begin
            n_bad++;
            $display("FAIL rstret_clear: we=%0b fv=%0b rpv=%0b busy=%0b addr=%0h data=%0h rpc=%0h cnt=%0h, all required 0",
                     reg_we, fwd_valid, ret_pc_valid, stage_busy, reg_wr_addr, reg_wr_data, ret_pc, retire_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            ret_pc_ack    = ($urandom_range(0, 2) == 0);
            set_op($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, 1'($urandom),
                   $urandom_range(0, 7) == 0, 4'($urandom), 16'($urandom), 16'($urandom));
            tick();
            n_cmp++;
            if (reg_we !== (m_pend && m_wr) || fwd_valid !== (m_pend && m_wr)) begin
                n_bad++;
                $display("FAIL rnd_we: cycle %0d we=%0b fv=%0b, required %0b", i, reg_we, fwd_valid, m_pend && m_wr);
            end
            if (m_pend && m_wr) begin
                n_cmp++;
                if (reg_wr_addr !== m_rd || reg_wr_data !== m_val) begin
                    n_bad++;
                    $display("FAIL rnd_wdata: cycle %0d addr=%0h data=%0h, required %0h/%0h", i, reg_wr_addr, reg_wr_data, m_rd, m_val);
                end
            end
            n_cmp++;
            if (ret_pc_valid !== m_ret_wait || stage_busy !== m_ret_wait || (m_ret_wait && ret_pc !== m_ret_pc)) begin
                n_bad++;
                $display("FAIL rnd_ret: cycle %0d rpv=%0b busy=%0b rpc=%0h, required %0b/%0b/%0h",
                         i, ret_pc_valid, stage_busy, ret_pc, m_ret_wait, m_ret_wait, m_ret_pc);
            end
            n_cmp++;
            if (retire_cnt !== m_cnt) begin
                n_bad++;
                $display("FAIL rnd_cnt: cycle %0d cnt=%0h, required %0h", i, retire_cnt, m_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_pend = 0; m_wr = 0; m_ret_wait = 0; m_rd = 0; m_val = 0; m_ret_pc = 0; m_cnt = 0;
        test_reset();
        test_load();
        test_r0();
        test_stall();
        test_ret();
        test_stall_flush();
        test_random();
        test_wrap_and_ret_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
